// File: rtl/x_mux_ddr_muonic_alct_tx.sv
// Two-word-per-pair DDR transmit commutator: buffers word pairs and emits them as 80MHz 1st/2nd slots.
// Optional saturating underrun counter enabled by defining X_MUX_UNDERRUN_CNT_EN.
module x_mux_ddr_muonic_alct_tx #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] IDLE  = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             posneg,
  input  logic [WIDTH-1:0] din1st,
  input  logic [WIDTH-1:0] din2nd,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_1st,
  output logic             dout_valid,
  output logic             underrun
`ifdef X_MUX_UNDERRUN_CNT_EN
  ,
  output logic [7:0]       underrun_cnt
`endif
);

  logic [WIDTH-1:0] fifo_1st [2];
  logic [WIDTH-1:0] fifo_2nd [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             phase;
  logic             posneg_r;
  logic [WIDTH-1:0] shadow;

  logic boundary;
  logic push;
  logic pop;
  logic underrun_set;

  assign din_ready    = (count != 2'd2) & ~clr;
  assign boundary     = (phase == posneg_r);
  assign push         = din_valid & din_ready;
  assign pop          = boundary & (count != 2'd0) & ~clr;
  // A boundary with nothing to send, right after a second slot that carried data.
  assign underrun_set = boundary & (count == 2'd0) & dout_valid & ~clr;

  // Pair storage carries no reset: occupancy is tracked by count alone.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_1st[wr_ptr] <= din1st;
      fifo_2nd[wr_ptr] <= din2nd;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      phase      <= 1'b0;
      posneg_r   <= 1'b0;
      shadow     <= '0;
      dout       <= IDLE;
      dout_1st   <= 1'b0;
      dout_valid <= 1'b0;
      underrun   <= 1'b0;
    end else if (clr) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      phase      <= 1'b0;
      posneg_r   <= posneg;
      shadow     <= '0;
      dout       <= IDLE;
      dout_1st   <= 1'b0;
      dout_valid <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      phase  <= ~phase;
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop;
      count  <= count + {1'b0, push} - {1'b0, pop};
      if (boundary) begin
        dout_1st <= 1'b1;
        underrun <= underrun_set;
        if (pop) begin
          dout       <= fifo_1st[rd_ptr];
          shadow     <= fifo_2nd[rd_ptr];
          dout_valid <= 1'b1;
        end else begin
          dout       <= IDLE;
          dout_valid <= 1'b0;
        end
      end else begin
        // The boundary output still sits on dout: valid there means a shadow word is pending.
        dout_1st   <= 1'b0;
        underrun   <= 1'b0;
        dout_valid <= dout_valid & dout_1st;
        dout       <= (dout_valid & dout_1st) ? shadow : IDLE;
      end
    end
  end

`ifdef X_MUX_UNDERRUN_CNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      underrun_cnt <= 8'd0;
    end else if (clr) begin
      underrun_cnt <= 8'd0;
    end else if (underrun_set && (underrun_cnt != 8'hFF)) begin
      underrun_cnt <= underrun_cnt + 8'd1;
    end
  end
`endif

endmodule
